// File: rtl/struct_word_packer.sv
// rtl/struct_word_packer.sv - packs RECS 4-bit {last, first} records into one wide word, LSB-first
module struct_word_packer #(
    parameter int RECS = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [3:0]                   in_rec,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [4*RECS-1:0]            out_data,
    output logic [$clog2(RECS+1)-1:0]    out_count
);

    localparam int            CW       = $clog2(RECS + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(RECS);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [4*RECS-1:0]   acc_q, acc_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [CW-1:0]       cnt_inc;
    logic                accept;

    // Input side is open in FILL; in HOLD only when the held word leaves this cycle.
    always_comb begin
        in_ready = rst_n && ((state_q == FILL) || out_ready);
        accept   = in_valid && in_ready;
        cnt_inc  = cnt_q + CNT_ONE;
    end

    // Next-state: slot insertion, word close on full/flush, and same-cycle handoff.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (state_q)
            FILL: begin
                if (accept) begin
                    for (int k = 0; k < RECS; k++) begin
                        if (cnt_q == CW'(k)) begin
                            acc_d[4*k +: 4] = in_rec;
                        end
                    end
                    cnt_d = cnt_inc;
                    if ((cnt_inc == CNT_FULL) || flush) begin
                        state_d = HOLD;
                    end
                end else if (flush && (cnt_q != '0)) begin
                    // Empty flushes are dropped so no zero-count word is ever emitted.
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = FILL;
                    if (accept) begin
                        acc_d[3:0] = in_rec;
                        cnt_d      = CNT_ONE;
                        if (flush) begin
                            state_d = HOLD;
                        end
                    end
                end
            end
            default: begin
                state_d = FILL;
                acc_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // State, accumulator and fill count; reset discards any partial or held word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output word is only presented in HOLD so partial fills never leak out.
    always_comb begin
        out_valid = (state_q == HOLD);
        out_data  = out_valid ? acc_q : '0;
        out_count = out_valid ? cnt_q : '0;
    end

endmodule

// File: tb/tb_struct_word_packer.sv
// tb/tb_struct_word_packer.sv - scoreboard bench for struct_word_packer (RECS=4 directed, RECS=3 random)
module tb_struct_word_packer;

    logic        clk;
    logic        rst_n;

    logic        iv1, ir1, fl1, ov1, ordy1;
    logic [3:0]  rec1;
    logic [15:0] od1;
    logic [2:0]  oc1;

    logic        iv2, ir2, fl2, ov2, ordy2;
    logic [3:0]  rec2;
    logic [11:0] od2;
    logic [1:0]  oc2;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [15:0] d;
        logic [2:0]  c;
    } word_t;

    word_t      exp1[$];
    word_t      w1;
    logic [3:0] recq[$];
    logic [3:0] r2;

    struct_word_packer #(.RECS(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv1), .in_ready(ir1), .in_rec(rec1), .flush(fl1),
        .out_valid(ov1), .out_ready(ordy1), .out_data(od1), .out_count(oc1)
    );

    struct_word_packer #(.RECS(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv2), .in_ready(ir2), .in_rec(rec2), .flush(fl2),
        .out_valid(ov2), .out_ready(ordy2), .out_data(od2), .out_count(oc2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic word_t mk(input logic [15:0] d, input logic [2:0] c);
        word_t w;
        w.d = d;
        w.c = c;
        return w;
    endfunction

    task automatic send(input logic [3:0] r, input logic f);
        iv1  = 1'b1;
        rec1 = r;
        fl1  = f;
        @(negedge clk);
        chk("in_ready_open", 32'(ir1), 32'd1);
        @(posedge clk);
        #1;
        iv1 = 1'b0;
        fl1 = 1'b0;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Word monitor for the RECS=4 instance: pop the expected word on each transfer.
    always @(negedge clk) begin
        if (rst_n && ov1 && ordy1) begin
            if (exp1.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_word: got %0h/%0d with none expected", od1, oc1);
            end else begin
                w1 = exp1.pop_front();
                chk("word_data", 32'(od1), 32'(w1.d));
                chk("word_count", 32'(oc1), 32'(w1.c));
            end
        end
    end

    // Record monitor for the RECS=3 instance: outputs must replay accepted records in order.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ov2 && ordy2) begin
                chk("rnd_count_range", 32'((oc2 >= 2'd1) && (oc2 <= 2'd3)), 32'd1);
                for (int k = 0; k < 3; k++) begin
                    if (k < int'(oc2)) begin
                        if (recq.size() == 0) begin
                            vectors++;
                            miscompares++;
                            $display("FAIL rnd_extra_record: slot %0d got %0h with none pending", k, od2[4*k +: 4]);
                        end else begin
                            r2 = recq.pop_front();
                            chk("rnd_slot", 32'(od2[4*k +: 4]), 32'(r2));
                        end
                    end else begin
                        chk("rnd_unused_slot", 32'(od2[4*k +: 4]), 32'd0);
                    end
                end
            end
            if (iv2 && ir2) begin
                recq.push_back(rec2);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not reach its end");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        iv1 = 1'b0; rec1 = 4'h0; fl1 = 1'b0; ordy1 = 1'b1;
        iv2 = 1'b0; rec2 = 4'h0; fl2 = 1'b0; ordy2 = 1'b0;

        // Reset values while held low
        step();
        chk("rst_in_ready", 32'(ir1), 32'd0);
        chk("rst_out_valid", 32'(ov1), 32'd0);
        chk("rst_out_data", 32'(od1), 32'd0);
        chk("rst_out_count", 32'(oc1), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(ir1), 32'd1);
        step();

        // Full word
        exp1.push_back(mk(16'h4321, 3'd4));
        send(4'h1, 1'b0);
        send(4'h2, 1'b0);
        send(4'h3, 1'b0);
        chk("full_not_early", 32'(ov1), 32'd0);
        send(4'h4, 1'b0);
        chk("full_valid", 32'(ov1), 32'd1);
        chk("full_data", 32'(od1), 32'h4321);
        step();
        chk("full_one_cycle", 32'(ov1), 32'd0);

        // Backpressure
        ordy1 = 1'b0;
        exp1.push_back(mk(16'h0F69, 3'd4));
        send(4'h9, 1'b0);
        send(4'h6, 1'b0);
        send(4'hF, 1'b0);
        send(4'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(ov1), 32'd1);
            chk("bp_data", 32'(od1), 32'h0F69);
            chk("bp_in_ready", 32'(ir1), 32'd0);
        end
        @(posedge clk);
        #1;
        ordy1 = 1'b1;
        #1;
        chk("bp_release_ready", 32'(ir1), 32'd1);
        step();
        chk("bp_done_valid", 32'(ov1), 32'd0);
        chk("bp_done_ready", 32'(ir1), 32'd1);

        // Flush partial
        exp1.push_back(mk(16'h00BA, 3'd2));
        send(4'hA, 1'b0);
        send(4'hB, 1'b1);
        chk("flush_valid", 32'(ov1), 32'd1);
        chk("flush_count", 32'(oc1), 32'd2);
        step();
        chk("flush_done", 32'(ov1), 32'd0);

        // Flush with nothing accumulated
        fl1 = 1'b1;
        step();
        fl1 = 1'b0;
        @(negedge clk);
        chk("empty_flush_1", 32'(ov1), 32'd0);
        step();
        chk("empty_flush_2", 32'(ov1), 32'd0);

        // Handoff streaming
        exp1.push_back(mk(16'h4321, 3'd4));
        exp1.push_back(mk(16'h8765, 3'd4));
        exp1.push_back(mk(16'hCBA9, 3'd4));
        for (int i = 1; i <= 12; i++) begin
            send(4'(i), 1'b0);
        end
        chk("stream_last_valid", 32'(ov1), 32'd1);
        chk("stream_last_data", 32'(od1), 32'hCBA9);
        step();
        chk("stream_done", 32'(ov1), 32'd0);

        // Reset mid-word
        send(4'h5, 1'b0);
        send(4'h7, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 32'(ir1), 32'd0);
        chk("mid_rst_valid", 32'(ov1), 32'd0);
        chk("mid_rst_data", 32'(od1), 32'd0);
        chk("mid_rst_count", 32'(oc1), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        exp1.push_back(mk(16'h4321, 3'd4));
        send(4'h1, 1'b0);
        send(4'h2, 1'b0);
        send(4'h3, 1'b0);
        send(4'h4, 1'b0);
        chk("after_rst_data", 32'(od1), 32'h4321);
        step();

        // Random traffic on the RECS=3 instance
        for (int i = 0; i < 400; i++) begin
            iv2   = 1'($urandom_range(0, 1));
            rec2  = 4'($urandom);
            fl2   = ($urandom_range(0, 4) == 0);
            ordy2 = 1'($urandom_range(0, 1));
            step();
        end
        iv2   = 1'b0;
        ordy2 = 1'b1;
        fl2   = 1'b1;
        step();
        fl2 = 1'b0;
        for (int i = 0; i < 6; i++) step();

        chk("words_drained", 32'(exp1.size()), 32'd0);
        chk("records_drained", 32'(recq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
